// File: rtl/rggen_axi4lite_channel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rggen_axi4lite_channel_buffer
// Purpose  : Single-channel AXI4-Lite valid/ready buffer. It is a circular
//            FIFO of DEPTH entries of WIDTH bits. It can optionally bypass
//            the storage combinationally when the buffer is empty (BYPASS=1).
//            Upstream ready depends only on registered state.
// Ports    : i_clk      - clock, rising edge
//            i_rst_n    - asynchronous active-low reset
//            i_valid    - upstream valid
//            o_ready    - upstream ready (count < DEPTH)
//            i_payload  - upstream payload [WIDTH-1:0]
//            o_valid    - downstream valid
//            i_ready    - downstream ready
//            o_payload  - downstream payload [WIDTH-1:0]
//            o_count    - entries stored [COUNT_WIDTH-1:0]
// Config   : RGGEN_CHANNEL_BUFFER_PAYLOAD_RESET_EN - when defined, the
//            storage entries are asynchronously cleared by i_rst_n.
// Revision : 1.0 - initial release
// ============================================================================
module rggen_axi4lite_channel_buffer #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int BYPASS      = 1,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH-1:0]       i_payload,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_payload,
  output logic [COUNT_WIDTH-1:0] o_count
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0]   LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT  = COUNT_WIDTH'(DEPTH);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   wp_q, wp_d;
  logic [PTR_WIDTH-1:0]   rp_q, rp_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic empty;
  logic bypass_active;
  logic push_hs;
  logic pop_hs;
  logic mem_write;
  logic mem_read;

  assign empty   = (cnt_q == '0);
  assign o_ready = (cnt_q != FULL_CNT);

  generate
    if (BYPASS != 0) begin : g_bypass
      assign bypass_active = empty;
    end else begin : g_registered
      assign bypass_active = 1'b0;
    end
  endgenerate

  assign o_valid   = bypass_active ? i_valid   : !empty;
  assign o_payload = bypass_active ? i_payload : mem_q[rp_q];
  assign o_count   = cnt_q;

  assign push_hs = i_valid & o_ready;
  assign pop_hs  = o_valid & i_ready;

  // A beat that passes straight through in bypass touches no storage.
  assign mem_write = push_hs & !(bypass_active & i_ready);
  assign mem_read  = pop_hs  & !bypass_active;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (mem_write) begin
      wp_d = (wp_q == LAST_PTR) ? '0 : wp_q + 1'b1;
    end
    if (mem_read) begin
      rp_d = (rp_q == LAST_PTR) ? '0 : rp_q + 1'b1;
    end
    case ({mem_write, mem_read})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef RGGEN_CHANNEL_BUFFER_PAYLOAD_RESET_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_write) begin
      mem_q[wp_q] <= i_payload;
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (mem_write) begin
      mem_q[wp_q] <= i_payload;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rggen_axi4lite_channel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rggen_axi4lite_channel_buffer
// Purpose  : Self-checking bench. Two buffers (bypass and registered, DEPTH=3)
//            share one stimulus stream and are compared each cycle against
//            queue-based models of the channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rggen_axi4lite_channel_buffer;

  localparam int W = 8;
  localparam int D = 3;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [W-1:0]  i_payload = '0;

  logic          b_ready, b_valid, r_ready, r_valid;
  logic [W-1:0]  b_payload, r_payload;
  logic [CW-1:0] b_count, r_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [W-1:0] qb[$];
  logic [W-1:0] qr[$];

  always #5 clk = ~clk;

  rggen_axi4lite_channel_buffer #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) u_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(b_ready),
    .i_payload(i_payload), .o_valid(b_valid), .i_ready(i_ready),
    .o_payload(b_payload), .o_count(b_count)
  );

  rggen_axi4lite_channel_buffer #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) u_reg (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(r_ready),
    .i_payload(i_payload), .o_valid(r_valid), .i_ready(i_ready),
    .o_payload(r_payload), .o_count(r_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Outputs implied by the current model contents and current inputs.
  task automatic model_check();
    logic exp_valid;
    chk("byp_ready", b_ready, (qb.size() != D));
    chk("byp_count", b_count, qb.size());
    exp_valid = (qb.size() == 0) ? i_valid : 1'b1;
    chk("byp_valid", b_valid, exp_valid);
    if (exp_valid) chk("byp_payload", b_payload, (qb.size() == 0) ? i_payload : qb[0]);

    chk("reg_ready", r_ready, (qr.size() != D));
    chk("reg_count", r_count, qr.size());
    exp_valid = (qr.size() != 0);
    chk("reg_valid", r_valid, exp_valid);
    if (exp_valid) chk("reg_payload", r_payload, qr[0]);
  endtask

  // Advance the models across the coming rising edge.
  task automatic model_step();
    bit acc;
    acc = i_valid && (qb.size() != D);
    if (qb.size() == 0) begin
      if (acc && !i_ready) qb.push_back(i_payload);
    end else begin
      if (i_ready) void'(qb.pop_front());
      if (acc) qb.push_back(i_payload);
    end
    acc = i_valid && (qr.size() != D);
    if (qr.size() != 0 && i_ready) void'(qr.pop_front());
    if (acc) qr.push_back(i_payload);
  endtask

  // Drive one cycle of stimulus, check just before the edge, update models.
  task automatic cycle(input logic v, input logic [W-1:0] p, input logic r);
    @(negedge clk);
    i_valid   = v;
    i_payload = p;
    i_ready   = r;
    #2;
    model_check();
    model_step();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_count", r_count, 0);
    chk("rst_ready", r_ready, 1);
    chk("rst_reg_valid", r_valid, 0);
    chk("rst_byp_valid", b_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass pass-through, same-cycle payload, count stays 0
    cycle(1, 8'h11, 1);
    chk("pass_11", b_payload, 8'h11);
    chk("pass_cnt", b_count, 0);
    cycle(1, 8'h22, 1);
    chk("pass_22", b_payload, 8'h22);
    cycle(1, 8'h33, 1);
    chk("pass_33", b_payload, 8'h33);
    chk("reg_stream_22", r_payload, 8'h22);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);

    // Fill to full with downstream stalled; 0xD is held upstream
    cycle(1, 8'h0A, 0);
    cycle(1, 8'h0B, 0);
    cycle(1, 8'h0C, 0);
    after_edge();
    chk("full_ready", r_ready, 0);
    chk("full_count", r_count, 3);
    chk("full_head", r_payload, 8'h0A);
    chk("full_byp_count", b_count, 3);
    cycle(1, 8'h0D, 0);
    // Full with pop in the same cycle: no accept, count drops to 2
    cycle(1, 8'h0D, 1);
    after_edge();
    chk("fullpop_count", r_count, 2);
    chk("fullpop_ready", r_ready, 1);
    chk("fullpop_head", r_payload, 8'h0B);
    cycle(1, 8'h0D, 1);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);

    // Randomised stream with stalls (pointers wrap many times)
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 5));
    end
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);

    // Registered latency
    cycle(1, 8'h5A, 0);
    chk("lat_before", r_valid, 0);
    after_edge();
    chk("lat_after_valid", r_valid, 1);
    chk("lat_after_payload", r_payload, 8'h5A);
    cycle(1, 8'h77, 0);
    after_edge();
    chk("pre_rst_count", r_count, 2);

    // Asynchronous reset mid-stream
    #2;
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_count", r_count, 0);
    chk("mid_rst_valid", r_valid, 0);
    chk("mid_rst_byp_count", b_count, 0);
    chk("mid_rst_ready", r_ready, 1);
`ifdef RGGEN_CHANNEL_BUFFER_PAYLOAD_RESET_EN
    chk("mid_rst_payload", r_payload, 0);
`endif
    qb.delete();
    qr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'hC3, 0);
    after_edge();
    chk("post_rst_head", r_payload, 8'hC3);
    for (int i = 0; i < 100; i++) begin
      cycle(($urandom_range(0, 9) < 6), W'($urandom), ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
